// File: rtl/fetch_stage.sv
// Instruction fetch stage.
// Holds the program counter and issues in-order reads to instruction memory.
// Returned words are buffered in a small FIFO and presented to decode with
// their PC. A redirect flushes the buffer, marks in-flight fetches as stale
// and restarts fetch at the new target.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instruction,
    output logic [31:0] inst_pc
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic          r_started;
    logic [31:0]   r_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop_cnt;
    logic [CW-1:0] r_occupancy;

    logic [31:0]   r_tag_pc [FIFO_DEPTH];
    logic [PW-1:0] r_tag_wr;
    logic [PW-1:0] r_tag_rd;

    logic [31:0]   r_fifo_word [FIFO_DEPTH];
    logic [31:0]   r_fifo_pc   [FIFO_DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;

    logic          w_pop;
    logic          w_rsp;
    logic          w_drop;
    logic          w_keep;
    logic          w_req_valid;
    logic          w_accept;
    logic [CW:0]   w_used;
    logic [31:0]   w_redirect_pc;

    // Pointer advance with wrap for any depth, not just powers of two.
    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        if (p == PW'(FIFO_DEPTH - 1))
            return '0;
        else
            return p + PW'(1);
    endfunction

    // Handshake qualifiers and the fetch credit. A response with nothing
    // outstanding is a protocol violation and is ignored entirely.
    always_comb begin
        w_pop         = inst_valid && inst_ready;
        w_rsp         = imem_rsp_valid && (r_outstanding != '0);
        w_drop        = w_rsp && (r_drop_cnt != '0);
        w_keep        = w_rsp && (r_drop_cnt == '0) && !redirect_valid;
        w_used        = {1'b0, r_outstanding} + {1'b0, r_occupancy} - {{CW{1'b0}}, w_pop};
        w_req_valid   = r_started && !redirect_valid && (w_used < (CW+1)'(FIFO_DEPTH));
        w_accept      = w_req_valid && imem_req_ready;
        w_redirect_pc = redirect_pc & ~32'h3;
    end

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_pc;
    assign inst_valid     = (r_occupancy != '0);
    assign instruction    = r_fifo_word[r_rd];
    assign inst_pc        = r_fifo_pc[r_rd];

    // Holds off the first request until one edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_started <= 1'b0;
        else
            r_started <= 1'b1;
    end

    // PC, outstanding count and stale-response drop count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else if (redirect_valid) begin
            // No request is accepted in a redirect cycle; every response
            // still owed, minus the one arriving now, belongs to the old path.
            r_pc          <= w_redirect_pc;
            r_outstanding <= r_outstanding - CW'(w_rsp);
            r_drop_cnt    <= r_outstanding - CW'(w_rsp);
        end else begin
            if (w_accept)
                r_pc <= r_pc + 32'd4;
            r_outstanding <= r_outstanding + CW'(w_accept) - CW'(w_rsp);
            if (w_drop)
                r_drop_cnt <= r_drop_cnt - CW'(1);
        end
    end

    // PC-tag queue: one entry per accepted request, retired by every
    // response. Stale tags are retired as their responses are dropped, so
    // the queue stays aligned with the in-order return stream across a flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                r_tag_pc[i] <= '0;
            r_tag_wr <= '0;
            r_tag_rd <= '0;
        end else begin
            if (w_accept) begin
                r_tag_pc[r_tag_wr] <= r_pc;
                r_tag_wr           <= f_inc(r_tag_wr);
            end
            if (w_rsp)
                r_tag_rd <= f_inc(r_tag_rd);
        end
    end

    // Instruction buffer. Credit guarantees a kept response always has room.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_word[i] <= '0;
                r_fifo_pc[i]   <= '0;
            end
            r_wr        <= '0;
            r_rd        <= '0;
            r_occupancy <= '0;
        end else if (redirect_valid) begin
            r_wr        <= '0;
            r_rd        <= '0;
            r_occupancy <= '0;
        end else begin
            if (w_keep) begin
                r_fifo_word[r_wr] <= imem_rsp_data;
                r_fifo_pc[r_wr]   <= r_tag_pc[r_tag_rd];
                r_wr              <= f_inc(r_wr);
            end
            if (w_pop)
                r_rd <= f_inc(r_rd);
            case ({w_keep, w_pop})
                2'b10:   r_occupancy <= r_occupancy + CW'(1);
                2'b01:   r_occupancy <= r_occupancy - CW'(1);
                default: r_occupancy <= r_occupancy;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: a memory model with variable in-order latency
// and a reference model that tracks the expected request and delivery
// streams per redirect epoch.
module tb_fetch_stage;

    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam int          DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] instruction;
    logic [31:0] inst_pc;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .instruction    (instruction),
        .inst_pc        (inst_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    req_t        memq[$];
    logic [31:0] got_pc[$];
    logic [31:0] acc_addr[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          buffered = 0;
    int          last_due = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          n_acc = 0;
    int          n_del = 0;
    bit          started = 0;
    logic [31:0] seg_pc = RPC;
    logic [31:0] req_pc = RPC;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    // One clock cycle: check at the falling edge, advance the model, then
    // drive the memory response for the next cycle just after the rising edge.
    task automatic tick();
        bit   acc, del, red, pop;
        logic exp_rv;
        req_t e;
        int   lat;
        @(negedge clk);
        red    = redirect_valid;
        pop    = (buffered != 0) && inst_ready;
        exp_rv = started && !red && ((memq.size() + buffered - (pop ? 1 : 0)) < DEPTH);
        total++;
        if (imem_req_valid !== exp_rv) begin
            bad++;
            $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, exp_rv);
        end
        total++;
        if (inst_valid !== (buffered != 0)) begin
            bad++;
            $display("FAIL inst_valid cyc=%0d got=%b exp=%b", cyc, inst_valid, buffered != 0);
        end
        if (imem_req_valid === 1'b1) begin
            total++;
            if (imem_req_addr !== req_pc) begin
                bad++;
                $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, req_pc);
            end
        end
        acc = (imem_req_valid === 1'b1) && imem_req_ready;
        del = (inst_valid === 1'b1) && inst_ready && !red && (buffered > 0);
        if (del) begin
            total++;
            if (inst_pc !== seg_pc || instruction !== memword(seg_pc)) begin
                bad++;
                $display("FAIL deliver cyc=%0d got pc=%h word=%h exp pc=%h word=%h",
                         cyc, inst_pc, instruction, seg_pc, memword(seg_pc));
            end
            got_pc.push_back(inst_pc);
            n_del++;
            seg_pc = seg_pc + 32'd4;
            buffered--;
        end
        if (imem_rsp_valid && memq.size() != 0) begin
            e = memq.pop_front();
            if (!red && e.epoch == epoch)
                buffered++;
        end
        if (acc) begin
            lat     = int'($urandom_range(lat_max, lat_min));
            e.addr  = imem_req_addr;
            e.epoch = epoch;
            e.due   = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
            last_due = e.due;
            memq.push_back(e);
            acc_addr.push_back(imem_req_addr);
            n_acc++;
            req_pc = req_pc + 32'd4;
        end
        if (red) begin
            epoch++;
            buffered = 0;
            seg_pc   = redirect_pc & ~32'h3;
            req_pc   = seg_pc;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (memq.size() != 0 && memq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memword(memq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        memq.delete();
        buffered = 0;
        epoch    = 0;
        started  = 0;
        seg_pc   = RPC;
        req_pc   = RPC;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 ||
            instruction !== 32'h0 || inst_pc !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs got req_v=%b inst_v=%b instr=%h pc=%h exp all zero",
                     imem_req_valid, inst_valid, instruction, inst_pc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (imem_req_valid !== 1'b0) begin
            bad++;
            $display("FAIL release_no_edge got req_v=%b exp 0", imem_req_valid);
        end
        @(posedge clk);
        #1;
        cyc++;
        last_due = cyc;
        started  = 1;
    endtask

    task automatic test_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        lat_min = 1; lat_max = 1;
        do_reset();
        acc_addr.delete();
        tick();
        total++;
        if (acc_addr.size() != 1 || acc_addr[0] !== RPC) begin
            bad++;
            $display("FAIL first_req got n=%0d exp addr=%h", acc_addr.size(), RPC);
        end
    endtask

    task automatic test_stream();
        do_reset();
        n_acc = 0; n_del = 0;
        repeat (20) tick();
        total++;
        if (n_acc != 20 || n_del != 18) begin
            bad++;
            $display("FAIL stream_rate got acc=%0d del=%0d exp acc=20 del=18", n_acc, n_del);
        end
    endtask

    task automatic test_stall();
        inst_ready = 1'b0;
        n_acc = 0;
        repeat (10) tick();
        total++;
        if (n_acc > DEPTH || imem_req_valid !== 1'b0 || inst_valid !== 1'b1) begin
            bad++;
            $display("FAIL stall got acc=%0d req_v=%b inst_v=%b exp acc<=%0d req_v=0 inst_v=1",
                     n_acc, imem_req_valid, inst_valid, DEPTH);
        end
        inst_ready = 1'b1;
        repeat (10) tick();
    endtask

    task automatic test_redirect_drop();
        int n;
        lat_min = 3; lat_max = 3;
        do_reset();
        n = 0;
        while (memq.size() < 2 && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (memq.size() < 2) begin
            bad++;
            $display("FAIL two_outstanding got %0d exp 2", memq.size());
        end
        got_pc.delete();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        n = 0;
        while (got_pc.size() < 2 && n < 30) begin
            tick();
            n++;
        end
        total++;
        if (got_pc.size() < 2 || got_pc[0] !== 32'h100 || got_pc[1] !== 32'h104) begin
            bad++;
            $display("FAIL redirect_drop got n=%0d first=%h exp 100,104",
                     got_pc.size(), (got_pc.size() != 0) ? got_pc[0] : 32'hx);
        end
    endtask

    task automatic test_redirect_same_cycle();
        int n;
        lat_min = 1; lat_max = 1;
        repeat (6) tick();
        n = 0;
        while (!(imem_rsp_valid && inst_valid === 1'b1) && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (!(imem_rsp_valid && inst_valid === 1'b1)) begin
            bad++;
            $display("FAIL same_cycle_setup got rsp=%b inst_v=%b exp 1 1", imem_rsp_valid, inst_valid);
        end
        got_pc.delete();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        tick();
        redirect_valid = 1'b0;
        total++;
        if (inst_valid !== 1'b0) begin
            bad++;
            $display("FAIL redirect_flush got inst_v=%b exp 0", inst_valid);
        end
        repeat (10) tick();
        total++;
        if (got_pc.size() == 0 || got_pc[0] !== 32'h40) begin
            bad++;
            $display("FAIL same_cycle_target got n=%0d exp first pc 40", got_pc.size());
        end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        acc_addr.delete();
        repeat (8) tick();
        total++;
        if (acc_addr.size() < 3 || acc_addr[0] !== 32'hFFFF_FFF8 ||
            acc_addr[1] !== 32'hFFFF_FFFC || acc_addr[2] !== 32'h0) begin
            bad++;
            $display("FAIL wrap got n=%0d exp FFFFFFF8,FFFFFFFC,0", acc_addr.size());
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        tick();
        redirect_valid = 1'b0;
        acc_addr.delete();
        repeat (6) tick();
        total++;
        if (acc_addr.size() == 0 || acc_addr[0] !== 32'h200) begin
            bad++;
            $display("FAIL unaligned_target got n=%0d exp first addr 200", acc_addr.size());
        end
    endtask

    task automatic test_async_reset();
        inst_ready = 1'b1;
        repeat (4) tick();
        inst_ready = 1'b0;
        repeat (6) tick();
        total++;
        if (inst_valid !== 1'b1 || buffered != DEPTH) begin
            bad++;
            $display("FAIL fifo_full got inst_v=%b buffered=%0d exp 1 %0d", inst_valid, buffered, DEPTH);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            bad++;
            $display("FAIL async_reset got inst_v=%b req_v=%b exp 0 0", inst_valid, imem_req_valid);
        end
        do_reset();
        inst_ready = 1'b1;
        acc_addr.delete();
        repeat (3) tick();
        total++;
        if (acc_addr.size() == 0 || acc_addr[0] !== RPC) begin
            bad++;
            $display("FAIL resume_after_reset got n=%0d exp first addr %h", acc_addr.size(), RPC);
        end
    endtask

    task automatic test_random();
        lat_min = 1; lat_max = 4;
        do_reset();
        n_del = 0;
        for (int i = 0; i < 1500; i++) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            inst_ready     = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 29) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom;
            end else begin
                redirect_valid = 1'b0;
            end
            tick();
        end
        redirect_valid = 1'b0;
        total++;
        if (n_del < 100) begin
            bad++;
            $display("FAIL random_progress got del=%0d exp >=100", n_del);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_drop();
        test_redirect_same_cycle();
        test_wrap();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage: holds the program counter, issues in-order reads to instruction memory over a valid/ready request channel and buffers returned words in a small FIFO. It presents them to the decode/control path as a 32-bit `instruction` with its PC, under a valid/ready handshake. A redirect from the branch/jump resolution logic flushes the FIFO and all in-flight fetches and restarts fetch at the new target.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0)
- FIFO_DEPTH, 2, instruction buffer entries; also the cap on outstanding-plus-buffered fetches (≥2)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  fetch address (word aligned)
- imem_rsp_valid  in  1  read data valid; responses return in request order, ≥1 cycle after acceptance
- imem_rsp_data  in  32  instruction word
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  32  new fetch target; bits [1:0] ignored (treated as 0)
- inst_valid  out  1  `instruction`/`inst_pc` valid toward decode
- inst_ready  in  1  decode consumes the entry
- instruction  out  32  fetched word, bit 31 = funct7 MSB
- inst_pc  out  32  address of `instruction`

## Operation
- State: `pc` (32), `outstanding` (accepted, unanswered requests), `drop_cnt` (stale responses still to discard), FIFO of {word, pc}, `occupancy`. Counter width clog2(FIFO_DEPTH+1).
- Credit: imem_req_valid = !redirect_valid && (outstanding + occupancy − pop) < FIFO_DEPTH, where pop = inst_valid && inst_ready. The FIFO therefore never overflows and no push is ever refused.
- imem_req_addr = pc. On accept (valid && ready): pc ← pc + 4 (mod 2^32, wraps 32'hFFFF_FFFC → 0), outstanding +1. The per-request PC goes into a PC-tag queue of FIFO_DEPTH entries, matched to responses in order.
- Response (imem_rsp_valid): outstanding −1. If drop_cnt > 0: discard, drop_cnt −1. Otherwise push {imem_rsp_data, tagged pc}.
- imem_rsp_valid with outstanding == 0 is a protocol violation. It is ignored with no state change.
- Pop: inst_valid && inst_ready removes the head; inst_valid = occupancy ≠ 0. Push and pop in the same cycle leave occupancy unchanged.
- Redirect (highest priority):
  - pc ← {redirect_pc[31:2], 2'b00}.
  - FIFO emptied, occupancy ← 0. Any same-cycle push/pop is void.
  - drop_cnt ← outstanding − imem_rsp_valid. The response arriving in the redirect cycle is itself discarded.
  - PC-tag queue cleared of live entries. Stale entries are consumed by drop_cnt.
  - No request is issued in the redirect cycle.
- Back-to-back redirects: each recomputes drop_cnt from the current outstanding. The last target wins.
- During drop_cnt > 0, new requests to the redirected pc may be issued and accepted. Their responses are kept only after drop_cnt reaches 0, which in-order return guarantees.

## Timing
- Reset (rst_n low, async): pc = RESET_PC, outstanding = drop_cnt = occupancy = 0, imem_req_valid = 0, inst_valid = 0, instruction = 0, inst_pc = 0.
- First rising edge after rst_n high: imem_req_valid = 1, imem_req_addr = RESET_PC.
- FIFO outputs are registered. A response pushed at edge N is visible on inst_valid/instruction after edge N, i.e. response-to-decode latency is 1 cycle.
- imem_req_valid depends combinationally on redirect_valid, inst_ready and internal state only. It never depends on imem_req_ready.
- With single-cycle memory, imem_req_ready = 1 and inst_ready = 1, throughput is one instruction per cycle after a 2-cycle startup.
- Redirect at edge N: the first request to the target is issued in cycle N+1. The earliest target instruction appears on inst_valid at N+3.
- rst_n asserted mid-operation: all state clears immediately. In-flight memory responses after reset release are the environment's responsibility (memory is reset together).

## Test plan
- Reset, single-cycle memory, inst_ready = 1, RESET_PC = 0 → imem_req_addr 0,4,8,… on consecutive cycles; inst_pc 0,4,8 on consecutive cycles from cycle 3; instruction equals the memory word.
- inst_ready = 0 for 10 cycles → at most FIFO_DEPTH (2) requests accepted, then imem_req_valid = 0. On release, inst_pc continues with no gap or duplicate.
- Memory latency 3 cycles with 2 outstanding; redirect_pc = 0x100 asserted → both stale responses dropped; next inst_pc = 0x100, then 0x104.
- Redirect in the same cycle as imem_rsp_valid and inst_valid && inst_ready → that response is not delivered; drop_cnt = outstanding − 1; inst_valid = 0 the next cycle.
- pc = 0xFFFF_FFF8 free-running → addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; redirect_pc = 0x203 → fetch at 0x200.
- rst_n pulsed low mid-stream with FIFO full → inst_valid and imem_req_valid drop without a clock edge; fetch resumes at RESET_PC.
